// File: rtl/seq_counter_ctrl.sv
// Bounded up/down step counter with a start-edge FSM (IDLE/RUN/PAUSE/DONE),
// a prescaled step tick and an active-low seven-segment display of the count.
module seq_counter_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       up_dn,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    output logic [3:0] value,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [0:6] HEX3
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int              PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    value_q, value_d;
    logic [3:0]    lo_q, lo_d;
    logic [3:0]    hi_q, hi_d;
    logic          up_q, up_d;
    logic          err_q, err_d;
    logic          start_q, start_d;
    logic          edge_q, edge_d;
    logic          tick;
    logic [3:0]    step;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        value_d = value_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        up_d    = up_q;
        err_d   = err_q;
        start_d = start;
        edge_d  = start & ~start_q;
        tick    = (state_q == S_RUN) && (pre_q == PRE_MAX);
        step    = up_q ? value_q + 4'd1 : value_q - 4'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (edge_q) begin
                    pre_d = '0;
                    if (lo > hi) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b0;
                        up_d    = up_dn;
                        lo_d    = lo;
                        hi_d    = hi;
                        value_d = up_dn ? lo : hi;
                        state_d = (lo == hi) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (tick) begin
                    pre_d   = '0;
                    value_d = step;
                    // Reaching the terminal bound wins over a pending pause.
                    if (step == (up_q ? hi_q : lo_q)) state_d = S_DONE;
                    else if (pause)                   state_d = S_PAUSE;
                end else begin
                    pre_d = pre_q + 1'b1;
                    if (pause) state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (!pause) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, with an asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            value_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            up_q    <= 1'b1;
            err_q   <= 1'b0;
            // Resetting the sample high hides a start held through reset release.
            start_q <= 1'b1;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            value_q <= value_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            up_q    <= up_d;
            err_q   <= err_d;
            start_q <= start_d;
            edge_q  <= edge_d;
        end
    end

    assign value = value_q;
    assign err   = err_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done  = (state_q == S_DONE);

    always_comb begin
        HEX3 = 7'b1111111;
        if (state_q != S_IDLE) begin
            case (value_q)
                4'h0: HEX3 = 7'b0000001;
                4'h1: HEX3 = 7'b1001111;
                4'h2: HEX3 = 7'b0010010;
                4'h3: HEX3 = 7'b0000110;
                4'h4: HEX3 = 7'b1001100;
                4'h5: HEX3 = 7'b0100100;
                4'h6: HEX3 = 7'b0100000;
                4'h7: HEX3 = 7'b0001101;
                4'h8: HEX3 = 7'b0000000;
                4'h9: HEX3 = 7'b0000100;
                4'hA: HEX3 = 7'b0001000;
                4'hB: HEX3 = 7'b1100000;
                4'hC: HEX3 = 7'b0110001;
                4'hD: HEX3 = 7'b1000010;
                4'hE: HEX3 = 7'b0110000;
                default: HEX3 = 7'b0111000;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed bench for seq_counter_ctrl with TICK_DIV=4; expected values are hand-computed.
module tb_seq_counter_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic       pause;
    logic       up_dn;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] value;
    logic       busy;
    logic       done;
    logic       err;
    logic [0:6] HEX3;

    int n_checks = 0;
    int n_errors = 0;

    seq_counter_ctrl #(.TICK_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .pause (pause),
        .up_dn (up_dn),
        .lo    (lo),
        .hi    (hi),
        .value (value),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .HEX3  (HEX3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Rising start: edge registered on the first edge, accepted on the second.
    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        pause = 1'b0;
        up_dn = 1'b1;
        lo    = 4'd1;
        hi    = 4'd3;
        cyc(2);
        check("rst_value", value, 4'd0);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        check("rst_err",   err,   1'b0);
        check("rst_hex",   HEX3,  7'b1111111);

        // Start held high across reset release must not count.
        reset = 1'b1;
        cyc(3);
        check("held_start_busy", busy, 1'b0);
        start = 1'b0;
        cyc(1);

        // Up count 1..3.
        do_start();
        check("up_load",  value, 4'd1);
        check("up_busy",  busy,  1'b1);
        cyc(3);
        check("up_hold1", value, 4'd1);
        cyc(1);
        check("up_step2", value, 4'd2);
        cyc(3);
        check("up_hold2", value, 4'd2);
        check("up_notdone", done, 1'b0);
        cyc(1);
        check("up_step3", value, 4'd3);
        check("up_done",  done,  1'b1);
        check("up_busy0", busy,  1'b0);
        check("up_hex3",  HEX3,  7'b0000110);

        // Down count 5..2, started from DONE.
        up_dn = 1'b0;
        lo    = 4'd2;
        hi    = 4'd5;
        do_start();
        check("dn_load", value, 4'd5);
        check("dn_busy", busy,  1'b1);
        cyc(4);
        check("dn_4", value, 4'd4);
        cyc(4);
        check("dn_3", value, 4'd3);
        cyc(3);
        check("dn_busy_pre", busy, 1'b1);
        cyc(1);
        check("dn_2",     value, 4'd2);
        check("dn_done",  done,  1'b1);
        check("dn_busy0", busy,  1'b0);
        cyc(4);
        check("dn_holds", value, 4'd2);

        // Rejected start: lo > hi.
        up_dn = 1'b1;
        lo    = 4'd7;
        hi    = 4'd3;
        do_start();
        check("bad_err",   err,   1'b1);
        check("bad_busy",  busy,  1'b0);
        check("bad_done",  done,  1'b0);
        check("bad_hex",   HEX3,  7'b1111111);
        check("bad_value", value, 4'd2);

        // lo == hi goes straight to DONE and clears err.
        lo = 4'd9;
        hi = 4'd9;
        do_start();
        check("eq_err",   err,   1'b0);
        check("eq_done",  done,  1'b1);
        check("eq_value", value, 4'd9);
        check("eq_hex",   HEX3,  7'b0000100);

        // Restart from DONE; a start during RUN is ignored.
        lo = 4'd3;
        hi = 4'd6;
        do_start();
        check("re_load", value, 4'd3);
        check("re_busy", busy,  1'b1);
        lo    = 4'd0;
        hi    = 4'd15;
        up_dn = 1'b0;
        do_start();
        check("ign_value", value, 4'd3);
        cyc(2);
        check("ign_step4", value, 4'd4);
        cyc(4);
        check("ign_step5", value, 4'd5);
        cyc(4);
        check("ign_step6", value, 4'd6);
        check("ign_done",  done,  1'b1);

        // Pause for 10 cycles mid-RUN: value and prescaler frozen.
        up_dn = 1'b1;
        lo    = 4'd0;
        hi    = 4'd9;
        do_start();
        check("pz_load", value, 4'd0);
        cyc(2);
        pause = 1'b1;
        cyc(1);
        check("pz_busy", busy, 1'b1);
        cyc(9);
        check("pz_frozen", value, 4'd0);
        pause = 1'b0;
        cyc(1);
        check("pz_resume0", value, 4'd0);
        cyc(1);
        check("pz_resume1", value, 4'd1);

        // Tick and pause coincide: step applies, then PAUSE.
        cyc(3);
        check("pzt_pre", value, 4'd1);
        pause = 1'b1;
        cyc(1);
        check("pzt_step", value, 4'd2);
        check("pzt_busy", busy,  1'b1);
        cyc(3);
        check("pzt_hold", value, 4'd2);
        pause = 1'b0;
        cyc(1);

        // Asynchronous reset mid-RUN at value 2.
        #2;
        reset = 1'b0;
        #1;
        check("arst_value", value, 4'd0);
        check("arst_busy",  busy,  1'b0);
        check("arst_err",   err,   1'b0);
        check("arst_hex",   HEX3,  7'b1111111);
        #1;
        reset = 1'b1;
        cyc(2);
        check("arst_idle", busy, 1'b0);

        // Terminal step while pause is high: DONE beats PAUSE.
        lo = 4'd0;
        hi = 4'd1;
        do_start();
        cyc(3);
        pause = 1'b1;
        cyc(1);
        check("prio_value", value, 4'd1);
        check("prio_done",  done,  1'b1);
        check("prio_busy",  busy,  1'b0);
        pause = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_counter_ctrl.md
SEQ_COUNTER_CTRL -- requirements
Module: seq_counter_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per count step (minimum 2).
REQ-002 SHALL have port clock  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  level input; each 0->1 transition is one start request.
REQ-005 SHALL have port pause  input  1  level; high holds the count while running.
REQ-006 SHALL have port up_dn  input  1  direction; 1 = up, 0 = down; sampled only on an accepted start.
REQ-007 SHALL have port lo  input  4  lower bound, sampled only on an accepted start.
REQ-008 SHALL have port hi  input  4  upper bound, sampled only on an accepted start.
REQ-009 SHALL have port value  output  4  current count.
REQ-010 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port err  output  1  sticky flag for a rejected start.
REQ-013 SHALL have port HEX3  output  [0:6]  active-low seven-segment pattern; bit 0 = segment a.

Function
REQ-014 SHALL register start once and assert an internal edge pulse for exactly one cycle per 0->1 transition.
REQ-015 SHALL implement states IDLE, RUN, PAUSE, DONE as a registered FSM.
REQ-016 SHALL accept a start edge in IDLE or DONE only; edges in RUN/PAUSE are ignored.
REQ-017 SHALL, on an accepted start with lo>hi: stay in or return to IDLE, set err=1, leave value unchanged.
REQ-018 SHALL, on an accepted start with lo<=hi: clear err, latch direction and bounds, and load value=lo (up) or hi (down).
REQ-019 SHALL, on an accepted start with lo<=hi, go to RUN; if lo==hi, go directly to DONE instead.
REQ-020 SHALL clear the prescaler to 0 on every accepted start.
REQ-021 SHALL advance the prescaler only in RUN, hold it in PAUSE, and issue tick when it equals TICK_DIV-1, then wrap to 0.
REQ-022 SHALL, on tick in RUN, step value by +1 (up) or -1 (down); first step occurs TICK_DIV cycles after entering RUN.
REQ-023 SHALL enter DONE in the same clock edge the stepped value equals the terminal bound (hi up, lo down); value holds thereafter.
REQ-024 SHALL go RUN->PAUSE when pause=1 and PAUSE->RUN when pause=0, each taking effect on the next edge.
REQ-025 SHALL, when tick and pause=1 coincide in RUN, apply the step and then enter PAUSE.
REQ-026 SHALL, when a step reaches the terminal bound while pause=1, enter DONE (DONE has priority over PAUSE).
REQ-027 SHALL never wrap value outside the latched [lo,hi] range.
REQ-028 SHALL drive HEX3=7'b1111111 in IDLE; otherwise decode value combinationally.
REQ-029 SHALL use these decode patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-030 SHALL derive busy and done combinationally from the state register only.

Reset
REQ-031 SHALL, while reset=0, force state IDLE, value=0, prescaler=0, err=0, and the start edge register=0, independent of clock.
REQ-032 SHALL, on reset asserted mid-RUN, abort immediately; HEX3 reads 1111111 and busy=0 within the same cycle.
REQ-033 SHALL ignore a start held high through reset release until it falls and rises again.

Verification (TICK_DIV=4)
REQ-034 SHALL be tested with up count lo=1, hi=3, start pulse -> value 1 then 2 @+4 cycles then 3 @+8; done=1 at that edge; HEX3=0000110.
REQ-035 SHALL be tested with down count lo=2, hi=5, up_dn=0 -> value sequence 5,4,3,2 every 4 cycles; DONE at 2; busy falls with done rise.
REQ-036 SHALL be tested with pause=1 for 10 cycles mid-RUN -> value and prescaler frozen; step resumes with remaining tick count after pause=0.
REQ-037 SHALL be tested with lo=7, hi=3 start -> err=1, state IDLE, HEX3=1111111; a subsequent valid start clears err.
REQ-038 SHALL be tested with lo=hi=9 start -> DONE next edge, value=9, HEX3=0000100; a start in DONE restarts; starts during RUN are ignored.
REQ-039 SHALL be tested with reset pulsed low asynchronously mid-RUN at value=2 -> value=0, busy=0, err=0 without a clock edge.
